tea_core_arbiter: RTL and testbench

//   Shares one iterative TEA block-cipher core between two requesters (e.g. CTR keystream
//   and a direct-encrypt client). Round-robin arbitration, captures request operands,

---
 rtl/tea_core_arbiter_if.sv | 45 ++++
 rtl/tea_core_arbiter.sv | 114 +++++++++++
 tb/tb_tea_core_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tea_core_arbiter_if.sv
// Requester, response and TEA-core signal bundle for tea_core_arbiter.
// slave = arbiter side, master = requesters plus core side.
interface tea_core_arbiter_if;
    localparam int unsigned BLOCK_W = 64;
    localparam int unsigned KEY_W   = 128;

    logic               req0_valid;
    logic               req0_ready;
    logic [BLOCK_W-1:0] req0_block;
    logic [KEY_W-1:0]   req0_key;

    logic               req1_valid;
    logic               req1_ready;
    logic [BLOCK_W-1:0] req1_block;
    logic [KEY_W-1:0]   req1_key;

    logic               rsp0_valid;
    logic               rsp1_valid;
    logic [BLOCK_W-1:0] rsp_data;
    logic               rsp_err;

    logic               core_start;
    logic [BLOCK_W-1:0] core_plaintext;
    logic [KEY_W-1:0]   core_key;
    logic [BLOCK_W-1:0] core_ciphertext;
    logic               core_done;

    modport slave (
        input  req0_valid, req0_block, req0_key,
        input  req1_valid, req1_block, req1_key,
        input  core_ciphertext, core_done,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_data, rsp_err,
        output core_start, core_plaintext, core_key
    );

    modport master (
        output req0_valid, req0_block, req0_key,
        output req1_valid, req1_block, req1_key,
        output core_ciphertext, core_done,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data, rsp_err,
        input  core_start, core_plaintext, core_key
    );
endinterface

// File: rtl/tea_core_arbiter.sv
// Round-robin sharing of one iterative TEA core between two requesters,
// with a start/done sequencer and a watchdog that aborts a hung core.
module tea_core_arbiter #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    tea_core_arbiter_if.slave bus,
    output logic              busy
);
    localparam int unsigned       BLOCK_W    = 64;
    localparam int unsigned       KEY_W      = 128;
    localparam int unsigned       TIMER_W    = 16;
    localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = (TIMEOUT == 0) ? '0 : TIMER_W'(TIMEOUT - 1);
    localparam bit                WDOG_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state;
    logic                 grant;
    logic                 last_grant;
    logic [TIMER_W-1:0]   timer;

    logic                 any_valid_c;
    logic                 pick1_c;

    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign any_valid_c = bus.req0_valid | bus.req1_valid;
    assign pick1_c     = bus.req1_valid & (~bus.req0_valid | ~last_grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            grant              <= 1'b0;
            last_grant         <= 1'b1;
            timer              <= '0;
            busy               <= 1'b0;
            bus.req0_ready     <= 1'b0;
            bus.req1_ready     <= 1'b0;
            bus.rsp0_valid     <= 1'b0;
            bus.rsp1_valid     <= 1'b0;
            bus.rsp_data       <= '0;
            bus.rsp_err        <= 1'b0;
            bus.core_start     <= 1'b0;
            bus.core_plaintext <= '0;
            bus.core_key       <= '0;
        end else begin
            bus.req0_ready <= 1'b0;
            bus.req1_ready <= 1'b0;
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            bus.rsp_err    <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (any_valid_c) begin
                        bus.req0_ready     <= ~pick1_c;
                        bus.req1_ready     <= pick1_c;
                        bus.core_plaintext <= pick1_c ? bus.req1_block : bus.req0_block;
                        bus.core_key       <= pick1_c ? bus.req1_key   : bus.req0_key;
                        bus.core_start     <= 1'b1;
                        grant              <= pick1_c;
                        timer              <= '0;
                        busy               <= 1'b1;
                        state              <= RUN;
                    end
                end

                RUN: begin
                    // A done seen in the same cycle as expiry still returns real data.
                    if (bus.core_done) begin
                        bus.rsp_data   <= BLOCK_W'(bus.core_ciphertext);
                        bus.rsp0_valid <= ~grant;
                        bus.rsp1_valid <= grant;
                        bus.core_start <= 1'b0;
                        last_grant     <= grant;
                        state          <= DRAIN;
                    end else if (WDOG_EN && (timer == TIMER_LAST)) begin
                        bus.rsp_data   <= '0;
                        bus.rsp_err    <= 1'b1;
                        bus.rsp0_valid <= ~grant;
                        bus.rsp1_valid <= grant;
                        bus.core_start <= 1'b0;
                        last_grant     <= grant;
                        state          <= DRAIN;
                    end else if (timer != TIMER_MAX) begin
                        timer <= timer + TIMER_W'(1);
                    end
                end

                DRAIN: begin
                    // Core must show done low before a new start can be issued.
                    if (!bus.core_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    logic unused_key_w;
    assign unused_key_w = (KEY_W == 0);
endmodule

// File: tb/tb_tea_core_arbiter.sv
// Randomised bench for tea_core_arbiter: behavioural TEA core, two requesters,
// and a cycle-numbered transaction model that predicts every handshake.
module tb_tea_core_arbiter;
    localparam int unsigned TO = 40;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    tea_core_arbiter_if bus();

    tea_core_arbiter #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [63:0] tea(input logic [63:0] b, input logic [127:0] k);
        logic [31:0] v0, v1, sum;
        v0 = b[63:32]; v1 = b[31:0]; sum = 32'h0;
        for (int i = 0; i < 32; i++) begin
            sum = sum + 32'h9E3779B9;
            v0 = v0 + (((v1 << 4) + k[127:96]) ^ (v1 + sum) ^ ((v1 >> 5) + k[95:64]));
            v1 = v1 + (((v0 << 4) + k[63:32]) ^ (v0 + sum) ^ ((v0 >> 5) + k[31:0]));
        end
        return {v0, v1};
    endfunction

    // Stimulus knobs
    int lat_min = 1, lat_max = 8, hang_pct = 0, hold_min = 0, hold_max = 0;
    int gap_max = 3, wd_pct = 0, rst_pm = 0, rst_cycles = 0;
    bit req_en [2];
    bit fixed0 = 1'b0;

    // Environment state
    bit           s_rst = 1'b1;
    bit           s_ready [2];
    bit           r_valid [2];
    logic [63:0]  r_blk [2];
    logic [127:0] r_key [2];
    int           gap [2];
    int           cnt = 0, lat = 1, hold_left = 0;
    bit           hang = 1'b0;
    logic [63:0]  ct = '0;

    // Transaction model
    bit           chk_en = 1'b0;
    bit           has_txn = 1'b0, resp_known = 1'b0, free_known = 1'b0;
    bit           last_win = 1'b1, win = 1'b0, m_err = 1'b0;
    int           acc = 0, resp = 0, free_cyc = 0;
    logic [63:0]  m_data = '0;
    logic [63:0]  m_blk = '0;
    logic [127:0] m_key = '0;

    bit log_grants = 1'b0;
    int grant_q [$];

    task automatic drive_env();
        rst = (rst_cycles > 0) || (rst_pm != 0 && $urandom_range(999, 0) < rst_pm);
        if (rst_cycles > 0) rst_cycles--;

        // TEA core: done appears lat cycles after start rises, may linger after start drops
        if (s_rst) begin
            cnt = 0; hold_left = 0; bus.core_done = 1'b0;
        end else if (bus.core_start) begin
            if (cnt == 0) begin
                lat       = int'($urandom_range(lat_max, lat_min));
                hang      = ($urandom_range(99, 0) < hang_pct);
                hold_left = int'($urandom_range(hold_max, hold_min));
                ct        = tea(bus.core_plaintext, bus.core_key);
            end
            cnt++;
            bus.core_done = !hang && (cnt > lat);
        end else begin
            cnt = 0;
            if (bus.core_done && hold_left > 0) hold_left--;
            else bus.core_done = 1'b0;
        end
        bus.core_ciphertext = bus.core_done ? ct : {$urandom, $urandom};

        for (int k = 0; k < 2; k++) begin
            if (r_valid[k] && s_ready[k]) begin
                r_valid[k] = 1'b0;
                gap[k] = int'($urandom_range(gap_max, 0));
            end else if (r_valid[k]) begin
                if (wd_pct != 0 && $urandom_range(99, 0) < wd_pct) r_valid[k] = 1'b0;
            end else if (gap[k] > 0) begin
                gap[k]--;
            end else if (req_en[k]) begin
                r_valid[k] = 1'b1;
                r_blk[k]   = {$urandom, $urandom};
                r_key[k]   = {$urandom, $urandom, $urandom, $urandom};
                if (k == 0 && fixed0) begin
                    r_blk[0] = 64'h0123456789ABCDEF;
                    r_key[0] = '0;
                end
            end
        end
        bus.req0_valid = r_valid[0]; bus.req0_block = r_blk[0]; bus.req0_key = r_key[0];
        bus.req1_valid = r_valid[1]; bus.req1_block = r_blk[1]; bus.req1_key = r_key[1];
    endtask

    task automatic compare();
        bit live, rsp_now, start_exp, busy_exp;
        live      = has_txn && (cyc > acc);
        rsp_now   = has_txn && resp_known && (cyc == resp);
        start_exp = live && !(resp_known && cyc >= resp);
        busy_exp  = live && !(free_known && cyc >= free_cyc);
        check("req0_ready", 64'(bus.req0_ready), 64'(has_txn && cyc == acc + 1 && !win));
        check("req1_ready", 64'(bus.req1_ready), 64'(has_txn && cyc == acc + 1 && win));
        check("core_start", 64'(bus.core_start), 64'(start_exp));
        check("busy",       64'(busy),           64'(busy_exp));
        check("rsp0_valid", 64'(bus.rsp0_valid), 64'(rsp_now && !win));
        check("rsp1_valid", 64'(bus.rsp1_valid), 64'(rsp_now && win));
        check("rsp_err",    64'(bus.rsp_err),    64'(rsp_now && m_err));
        if (rsp_now) check("rsp_data", bus.rsp_data, m_data);
    endtask

    task automatic update_model();
        bit v0, v1, d;
        v0 = bus.req0_valid; v1 = bus.req1_valid; d = bus.core_done;
        if (rst) begin
            has_txn = 1'b0; resp_known = 1'b0; free_known = 1'b1;
            free_cyc = cyc + 1; last_win = 1'b1; chk_en = 1'b1;
            return;
        end
        if (has_txn && !resp_known && cyc > acc) begin
            if (d) begin
                resp = cyc + 1; resp_known = 1'b1; m_err = 1'b0; m_data = tea(m_blk, m_key);
            end else if (cyc == acc + int'(TO)) begin
                resp = cyc + 1; resp_known = 1'b1; m_err = 1'b1; m_data = '0;
            end
        end
        if (has_txn && resp_known && !free_known && cyc >= resp && !d) begin
            free_known = 1'b1; free_cyc = cyc + 1;
        end
        if (free_known && cyc >= free_cyc && (v0 || v1)) begin
            win = (v0 && v1) ? !last_win : v1;
            last_win = win; acc = cyc; has_txn = 1'b1;
            resp_known = 1'b0; free_known = 1'b0;
            m_blk = win ? bus.req1_block : bus.req0_block;
            m_key = win ? bus.req1_key   : bus.req0_key;
        end
    endtask

    task automatic cycle();
        @(posedge clk); #1;
        drive_env();
        @(negedge clk);
        if (chk_en) compare();
        update_model();
        s_rst = rst;
        s_ready[0] = bus.req0_ready;
        s_ready[1] = bus.req1_ready;
        if (log_grants && (bus.req0_ready || bus.req1_ready)) grant_q.push_back(bus.req1_ready ? 1 : 0);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset(input int n);
        rst_cycles = n;
        run(n + 1);
    endtask

    initial begin
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_block = '0; bus.req0_key = '0;
        bus.req1_valid = 1'b0; bus.req1_block = '0; bus.req1_key = '0;
        bus.core_done = 1'b0; bus.core_ciphertext = '0;
        for (int k = 0; k < 2; k++) begin
            req_en[k] = 1'b0; r_valid[k] = 1'b0; r_blk[k] = '0; r_key[k] = '0; gap[k] = 0; s_ready[k] = 1'b0;
        end

        // Single requester, fixed block and zero key, 32-cycle core
        do_reset(2);
        check("rst_rsp_data",   bus.rsp_data, 64'h0);
        check("rst_core_pt",    bus.core_plaintext, 64'h0);
        check("rst_core_key_h", bus.core_key[127:64], 64'h0);
        check("rst_core_key_l", bus.core_key[63:0], 64'h0);
        req_en[0] = 1'b1; fixed0 = 1'b1; lat_min = 32; lat_max = 32;
        run(120);

        // Both requesters held valid: grants must alternate starting with requester 0
        fixed0 = 1'b0; req_en[1] = 1'b1; gap_max = 0; lat_min = 1; lat_max = 8;
        do_reset(4);
        grant_q.delete();
        log_grants = 1'b1;
        run(60);
        log_grants = 1'b0;
        check("p2_grant_cnt", 64'(grant_q.size() >= 4), 64'(1));
        for (int i = 0; i < 4 && i < grant_q.size(); i++) check("p2_grant", 64'(grant_q[i]), 64'(i % 2));

        // 32-cycle core with both requesters contending
        lat_min = 32; lat_max = 32;
        run(150);

        // Hung core: watchdog aborts, then requester 1 is served
        hang_pct = 100;
        do_reset(2);
        run(100);
        hang_pct = 0;

        // done lingers 3 cycles after start drops
        lat_min = 4; lat_max = 4; hold_min = 3; hold_max = 3;
        do_reset(2);
        run(60);
        hold_min = 0; hold_max = 0;

        // Reset in the middle of a block, then normal service resumes
        lat_min = 20; lat_max = 20;
        begin
            int i;
            i = 0;
            while (i < 100 && !(has_txn && !resp_known && cyc > acc + 3)) begin
                cycle();
                i++;
            end
        end
        check("p6_inflight", 64'(has_txn && !resp_known), 64'(1));
        rst_cycles = 1;
        run(60);

        // Random mix
        lat_min = 1; lat_max = 12; hang_pct = 5; hold_min = 0; hold_max = 3;
        gap_max = 6; wd_pct = 3; rst_pm = 3;
        run(1500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
